// File: rtl/ms_spanbuf_ctl_pkg.sv
// Shared definitions for the memory-span buffer control slice.
//   DEPTH_DEF / BURST_DEF : default buffer depth and fill burst length
//   SEL_COLOR / SEL_Z     : buffer select encoding used on rq_sel / beat_sel
//   fill_state_e          : fill request FSM states
package ms_spanbuf_ctl_pkg;

   localparam int unsigned DEPTH_DEF = 16;
   localparam int unsigned BURST_DEF = 8;

   localparam logic SEL_COLOR = 1'b0;
   localparam logic SEL_Z     = 1'b1;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_REQ  = 1'b1
   } fill_state_e;

endpackage

// File: rtl/ms_spanbuf_ctl_if.sv
// RDRAM fill handshake between the span-buffer controller and the RDRAM
// interface.
//   rq_valid / rq_ready / rq_sel : 8-beat fill request and its target buffer
//   beat_valid / beat_sel        : returning data beat and its target buffer
// master = span-buffer controller, slave = RDRAM interface.
interface ms_spanbuf_ctl_if;

   logic rq_valid;
   logic rq_ready;
   logic rq_sel;
   logic beat_valid;
   logic beat_sel;

   modport master (
      output rq_valid, rq_sel,
      input  rq_ready, beat_valid, beat_sel
   );

   modport slave (
      input  rq_valid, rq_sel,
      output rq_ready, beat_valid, beat_sel
   );

endinterface

// File: rtl/ms_rb_ptr.sv
// Per-buffer pointer/credit tracker for one span buffer (color or Z).
//   clock, reset_l : clock, async active-low reset
//   clr            : synchronous hold-at-reset (diagnostic test mode)
//   add_burst      : fill request accepted for this buffer
//   beat           : RDRAM beat addressed to this buffer
//   kill_we        : suppress the RAM strobe, pointers still advance
//   rd_req         : pipeline read request
//   we, addr       : RAM write strobe and shared write/read address
//   rd_grant       : read accepted this cycle; rd_valid one cycle later
//   eligible       : room for another full burst (count + credit)
//   wr_stall       : beat dropped (no credit or full)
//   rd_stall       : read requested but not granted
//   wptr_idx/rptr_idx : pointer index bits for debug capture
module ms_rb_ptr #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned BURST = 8
) (
   input  logic                       clock,
   input  logic                       reset_l,
   input  logic                       clr,
   input  logic                       add_burst,
   input  logic                       beat,
   input  logic                       kill_we,
   input  logic                       rd_req,
   output logic                       we,
   output logic [$clog2(DEPTH)-1:0]   addr,
   output logic                       rd_grant,
   output logic                       rd_valid,
   output logic                       eligible,
   output logic                       wr_stall,
   output logic                       rd_stall,
   output logic [$clog2(DEPTH)-1:0]   wptr_idx,
   output logic [$clog2(DEPTH)-1:0]   rptr_idx
);

   localparam int unsigned IW = $clog2(DEPTH);
   localparam int unsigned PW = IW + 1;
   localparam int unsigned FW = PW + 1;

   logic [PW-1:0] wptr;
   logic [PW-1:0] rptr;
   logic [PW-1:0] credit;
   logic [PW-1:0] count;
   logic [FW-1:0] fill;
   logic          full;
   logic          empty;
   logic          wr_ok;

   // Extra wrap bit makes wptr - rptr span 0..DEPTH without ambiguity.
   assign count = wptr - rptr;
   assign full  = (count == PW'(DEPTH));
   assign empty = (count == '0);
   assign fill  = {1'b0, count} + {1'b0, credit};

   assign eligible = (fill <= FW'(DEPTH - BURST));

   assign wr_ok    = beat && !clr && (credit != '0) && !full;
   // A beat to this buffer owns the shared address, even if it is dropped.
   assign rd_grant = rd_req && !clr && !empty && !beat;

   assign we       = wr_ok && !kill_we;
   assign addr     = wr_ok ? wptr[IW-1:0] : rptr[IW-1:0];
   assign wr_stall = beat && !wr_ok;
   assign rd_stall = rd_req && !rd_grant;

   assign wptr_idx = wptr[IW-1:0];
   assign rptr_idx = rptr[IW-1:0];

   always_ff @(posedge clock or negedge reset_l) begin
      if (!reset_l) begin
         wptr     <= '0;
         rptr     <= '0;
         credit   <= '0;
         rd_valid <= 1'b0;
      end else if (clr) begin
         wptr     <= '0;
         rptr     <= '0;
         credit   <= '0;
         rd_valid <= 1'b0;
      end else begin
         if (wr_ok)    wptr <= wptr + PW'(1);
         if (rd_grant) rptr <= rptr + PW'(1);
         credit   <= credit + (add_burst ? PW'(BURST) : '0) - (wr_ok ? PW'(1) : '0);
         rd_valid <= rd_grant;
      end
   end

endmodule

// File: rtl/ms_spanbuf_ctl.sv
// Control stage for the color and Z span buffers.
//   clock, reset_l          : clock, async active-low reset
//   test_mode0              : hold pointers/credits/FSM at reset, no requests
//   test_mode1              : suppress we0/we1, pointers still advance
//   rb (master)             : RDRAM fill request and beat handshake
//   crd_req/zrd_req         : pipeline read requests
//   crd_valid/zrd_valid     : read data valid, one cycle after grant
//   we0/we1, addr0/addr1    : raw span-buffer strobes/addresses (combinational)
//   rb?{r,w}ptrd, stall??d  : registered debug copies for the status register
module ms_spanbuf_ctl
   import ms_spanbuf_ctl_pkg::*;
#(
   parameter int unsigned DEPTH = DEPTH_DEF,
   parameter int unsigned BURST = BURST_DEF
) (
   input  logic                       clock,
   input  logic                       reset_l,
   input  logic                       test_mode0,
   input  logic                       test_mode1,
   ms_spanbuf_ctl_if.master           rb,
   input  logic                       crd_req,
   input  logic                       zrd_req,
   output logic                       crd_valid,
   output logic                       zrd_valid,
   output logic                       we0,
   output logic                       we1,
   output logic [$clog2(DEPTH)-1:0]   addr0,
   output logic [$clog2(DEPTH)-1:0]   addr1,
   output logic [$clog2(DEPTH)-1:0]   rbcrptrd,
   output logic [$clog2(DEPTH)-1:0]   rbcwptrd,
   output logic [$clog2(DEPTH)-1:0]   rbzrptrd,
   output logic [$clog2(DEPTH)-1:0]   rbzwptrd,
   output logic                       stallcrd,
   output logic                       stallcwd,
   output logic                       stallzrd,
   output logic                       stallzwd
);

   localparam int unsigned IW = $clog2(DEPTH);

   fill_state_e state_q, state_d;
   logic        sel_q, sel_d;
   logic        rr_q, rr_d;
   logic        add_c, add_z;
   logic        rq_valid_c;

   logic          beat_c, beat_z;
   logic          elig_c, elig_z;
   logic          c_grant, z_grant;
   logic          c_wstall, c_rstall, z_wstall, z_rstall;
   logic [IW-1:0] c_widx, c_ridx, z_widx, z_ridx;

   assign beat_c = rb.beat_valid && (rb.beat_sel == SEL_COLOR);
   assign beat_z = rb.beat_valid && (rb.beat_sel == SEL_Z);

   ms_rb_ptr #(.DEPTH(DEPTH), .BURST(BURST)) u_cptr (
      .clock     (clock),
      .reset_l   (reset_l),
      .clr       (test_mode0),
      .add_burst (add_c),
      .beat      (beat_c),
      .kill_we   (test_mode1),
      .rd_req    (crd_req),
      .we        (we0),
      .addr      (addr0),
      .rd_grant  (c_grant),
      .rd_valid  (crd_valid),
      .eligible  (elig_c),
      .wr_stall  (c_wstall),
      .rd_stall  (c_rstall),
      .wptr_idx  (c_widx),
      .rptr_idx  (c_ridx)
   );

   ms_rb_ptr #(.DEPTH(DEPTH), .BURST(BURST)) u_zptr (
      .clock     (clock),
      .reset_l   (reset_l),
      .clr       (test_mode0),
      .add_burst (add_z),
      .beat      (beat_z),
      .kill_we   (test_mode1),
      .rd_req    (zrd_req),
      .we        (we1),
      .addr      (addr1),
      .rd_grant  (z_grant),
      .rd_valid  (zrd_valid),
      .eligible  (elig_z),
      .wr_stall  (z_wstall),
      .rd_stall  (z_rstall),
      .wptr_idx  (z_widx),
      .rptr_idx  (z_ridx)
   );

   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      rr_d       = rr_q;
      add_c      = 1'b0;
      add_z      = 1'b0;
      rq_valid_c = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (elig_c || elig_z) begin
               state_d = ST_REQ;
               if (elig_c && elig_z) sel_d = rr_q;
               else                  sel_d = elig_z ? SEL_Z : SEL_COLOR;
            end
         end
         ST_REQ: begin
            rq_valid_c = 1'b1;
            if (rb.rq_ready) begin
               add_c   = (sel_q == SEL_COLOR);
               add_z   = (sel_q == SEL_Z);
               rr_d    = ~rr_q;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // Test mode overrides everything, including an acceptance in this cycle.
      if (test_mode0) begin
         state_d    = ST_IDLE;
         sel_d      = SEL_COLOR;
         rr_d       = SEL_COLOR;
         add_c      = 1'b0;
         add_z      = 1'b0;
         rq_valid_c = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset_l) begin
      if (!reset_l) begin
         state_q <= ST_IDLE;
         sel_q   <= SEL_COLOR;
         rr_q    <= SEL_COLOR;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         rr_q    <= rr_d;
      end
   end

   assign rb.rq_valid = rq_valid_c;
   assign rb.rq_sel   = sel_q;

   always_ff @(posedge clock or negedge reset_l) begin
      if (!reset_l) begin
         rbcrptrd <= '0;
         rbcwptrd <= '0;
         rbzrptrd <= '0;
         rbzwptrd <= '0;
         stallcrd <= 1'b0;
         stallcwd <= 1'b0;
         stallzrd <= 1'b0;
         stallzwd <= 1'b0;
      end else begin
         rbcrptrd <= c_ridx;
         rbcwptrd <= c_widx;
         rbzrptrd <= z_ridx;
         rbzwptrd <= z_widx;
         stallcrd <= c_rstall;
         stallcwd <= c_wstall;
         stallzrd <= z_rstall;
         stallzwd <= z_wstall;
      end
   end

endmodule

// File: tb/tb_ms_spanbuf_ctl.sv
module tb_ms_spanbuf_ctl;

   logic       clock = 1'b0;
   logic       reset_l = 1'b0;
   logic       test_mode0 = 1'b0;
   logic       test_mode1 = 1'b0;
   logic       crd_req = 1'b0;
   logic       zrd_req = 1'b0;
   logic       crd_valid, zrd_valid, we0, we1;
   logic [3:0] addr0, addr1, rbcrptrd, rbcwptrd, rbzrptrd, rbzwptrd;
   logic       stallcrd, stallcwd, stallzrd, stallzwd;

   ms_spanbuf_ctl_if rb_if ();

   ms_spanbuf_ctl #(.DEPTH(16), .BURST(8)) dut (
      .clock      (clock),
      .reset_l    (reset_l),
      .test_mode0 (test_mode0),
      .test_mode1 (test_mode1),
      .rb         (rb_if.master),
      .crd_req    (crd_req),
      .zrd_req    (zrd_req),
      .crd_valid  (crd_valid),
      .zrd_valid  (zrd_valid),
      .we0        (we0),
      .we1        (we1),
      .addr0      (addr0),
      .addr1      (addr1),
      .rbcrptrd   (rbcrptrd),
      .rbcwptrd   (rbcwptrd),
      .rbzrptrd   (rbzrptrd),
      .rbzwptrd   (rbzwptrd),
      .stallcrd   (stallcrd),
      .stallcwd   (stallcwd),
      .stallzrd   (stallzrd),
      .stallzwd   (stallzwd)
   );

   always #5 clock = ~clock;

   int compared = 0;
   int mismatched = 0;
   int rdv_cnt = 0;

   // Expected write addresses, pushed when a beat is driven.
   logic [3:0] wq_c[$];
   logic [3:0] wq_z[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      compared++;
      mismatched++;
      $display("FAIL %s: bound expired", name);
   endtask

   always @(negedge clock) begin
      if (reset_l) begin
         if (we0) begin
            if (wq_c.size() == 0) fail_now("we0_unexpected");
            else chk("we0_addr", addr0, wq_c.pop_front());
         end
         if (we1) begin
            if (wq_z.size() == 0) fail_now("we1_unexpected");
            else chk("we1_addr", addr1, wq_z.pop_front());
         end
         if (crd_valid) rdv_cnt++;
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      chk("wq_c_drained", wq_c.size(), 0);
      chk("wq_z_drained", wq_z.size(), 0);
      wq_c.delete();
      wq_z.delete();
      rb_if.rq_ready = 1'b0;
      rb_if.beat_valid = 1'b0;
      rb_if.beat_sel = 1'b0;
      crd_req = 1'b0;
      zrd_req = 1'b0;
      test_mode0 = 1'b0;
      test_mode1 = 1'b0;
      reset_l = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      reset_l = 1'b1;
   endtask

   task automatic grant_req(input logic exp_sel, input string name);
      logic got;
      got = 1'b0;
      for (int n = 0; n < 10 && !got; n++) begin
         if (rb_if.rq_valid) begin
            chk(name, rb_if.rq_sel, exp_sel);
            rb_if.rq_ready = 1'b1;
            tick();
            rb_if.rq_ready = 1'b0;
            got = 1'b1;
         end else begin
            tick();
         end
      end
      if (!got) fail_now(name);
   endtask

   task automatic beat(input logic sel, input logic exp_we, input logic [3:0] exp_addr);
      rb_if.beat_valid = 1'b1;
      rb_if.beat_sel = sel;
      if (exp_we) begin
         if (sel) wq_z.push_back(exp_addr);
         else     wq_c.push_back(exp_addr);
      end
      tick();
      rb_if.beat_valid = 1'b0;
   endtask

   typedef struct {
      logic       rq_ready;
      logic       beat_valid;
      logic       e_rqv;
      logic       e_sel;
      logic       e_we0;
      logic [3:0] e_addr0;
      logic [3:0] e_rbcw;
      logic       e_stall;
   } vec_t;

   vec_t vt[26];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset, request order, first color burst, fill to 16 and overflow beat.
      vt[0]  = '{0, 0, 0, 0, 0, 4'd0, 4'd0, 0};
      vt[1]  = '{0, 0, 1, 0, 0, 4'd0, 4'd0, 0};
      vt[2]  = '{1, 0, 1, 0, 0, 4'd0, 4'd0, 0};
      vt[3]  = '{0, 0, 0, 0, 0, 4'd0, 4'd0, 0};
      vt[4]  = '{1, 1, 1, 1, 1, 4'd0, 4'd0, 0};
      vt[5]  = '{0, 1, 0, 1, 1, 4'd1, 4'd0, 0};
      vt[6]  = '{0, 1, 1, 0, 1, 4'd2, 4'd1, 0};
      for (int i = 7; i <= 11; i++) vt[i] = '{0, 1, 1, 0, 1, 4'(i - 4), 4'(i - 5), 0};
      vt[12] = '{0, 0, 1, 0, 0, 4'd0, 4'd7, 0};
      vt[13] = '{1, 0, 1, 0, 0, 4'd0, 4'd8, 0};
      vt[14] = '{0, 0, 0, 0, 0, 4'd0, 4'd8, 0};
      vt[15] = '{0, 1, 1, 1, 1, 4'd8, 4'd8, 0};
      for (int i = 16; i <= 22; i++) vt[i] = '{0, 1, 1, 1, 1, 4'(i - 7), 4'(i - 8), 0};
      vt[23] = '{0, 1, 1, 1, 0, 4'd0, 4'd15, 0};
      vt[24] = '{0, 0, 1, 1, 0, 4'd0, 4'd0, 1};
      vt[25] = '{0, 0, 1, 1, 0, 4'd0, 4'd0, 0};

      do_reset();
      for (int i = 0; i < 26; i++) begin
         rb_if.rq_ready = vt[i].rq_ready;
         rb_if.beat_valid = vt[i].beat_valid;
         rb_if.beat_sel = 1'b0;
         if (vt[i].e_we0) wq_c.push_back(vt[i].e_addr0);
         #2;
         chk($sformatf("v%0d_rq_valid", i), rb_if.rq_valid, vt[i].e_rqv);
         chk($sformatf("v%0d_rq_sel", i), rb_if.rq_sel, vt[i].e_sel);
         chk($sformatf("v%0d_we0", i), we0, vt[i].e_we0);
         chk($sformatf("v%0d_addr0", i), addr0, vt[i].e_addr0);
         chk($sformatf("v%0d_rbcwptrd", i), rbcwptrd, vt[i].e_rbcw);
         chk($sformatf("v%0d_stallcwd", i), stallcwd, vt[i].e_stall);
         tick();
      end
      rb_if.rq_ready = 1'b0;
      rb_if.beat_valid = 1'b0;

      // Read from empty Z, then after one Z beat.
      do_reset();
      grant_req(1'b0, "zrd_rq_c");
      grant_req(1'b1, "zrd_rq_z");
      zrd_req = 1'b1;
      tick();
      zrd_req = 1'b0;
      chk("zrd_empty_stall", stallzrd, 1);
      chk("zrd_empty_valid", zrd_valid, 0);
      beat(1'b1, 1'b1, 4'd0);
      zrd_req = 1'b1;
      #2;
      chk("zrd_grant_addr1", addr1, 0);
      tick();
      zrd_req = 1'b0;
      chk("zrd_valid_next", zrd_valid, 1);
      chk("zrd_no_stall", stallzrd, 0);
      chk("zrd_wptrd", rbzwptrd, 1);
      tick();
      chk("zrd_rptrd", rbzrptrd, 1);
      chk("zrd_valid_single", zrd_valid, 0);

      // Color beat and color read collide at count=3; Z read proceeds.
      do_reset();
      grant_req(1'b0, "col_rq_c");
      grant_req(1'b1, "col_rq_z");
      beat(1'b0, 1'b1, 4'd0);
      beat(1'b0, 1'b1, 4'd1);
      beat(1'b0, 1'b1, 4'd2);
      beat(1'b1, 1'b1, 4'd0);
      rb_if.beat_valid = 1'b1;
      rb_if.beat_sel = 1'b0;
      crd_req = 1'b1;
      zrd_req = 1'b1;
      wq_c.push_back(4'd3);
      #2;
      chk("col_z_read_addr1", addr1, 0);
      tick();
      rb_if.beat_valid = 1'b0;
      zrd_req = 1'b0;
      chk("col_crd_valid_stalled", crd_valid, 0);
      chk("col_zrd_valid", zrd_valid, 1);
      chk("col_stallcrd", stallcrd, 1);
      chk("col_stallzrd", stallzrd, 0);
      #2;
      chk("col_retry_addr0", addr0, 0);
      tick();
      crd_req = 1'b0;
      chk("col_crd_valid_retry", crd_valid, 1);
      chk("col_stallcrd_clear", stallcrd, 0);

      // Pointer wrap: 20 writes and 20 reads on color.
      begin
         int w, r, cr;
         do_reset();
         rdv_cnt = 0;
         w = 0; r = 0; cr = 0;
         for (int n = 0; n < 400 && (w < 20 || r < 20); n++) begin
            rb_if.rq_ready = rb_if.rq_valid;
            rb_if.beat_valid = 1'b0;
            crd_req = 1'b0;
            if (w < 20 && cr > 0) begin
               rb_if.beat_valid = 1'b1;
               rb_if.beat_sel = 1'b0;
               wq_c.push_back(4'(w % 16));
               cr--;
               w++;
            end else if (r < w) begin
               crd_req = 1'b1;
               r++;
            end
            if (rb_if.rq_valid && rb_if.rq_sel == 1'b0) cr += 8;
            tick();
         end
         rb_if.rq_ready = 1'b0;
         rb_if.beat_valid = 1'b0;
         crd_req = 1'b0;
         if (w < 20 || r < 20) fail_now("wrap_loop");
         tick();
         tick();
         chk("wrap_rbcwptrd", rbcwptrd, 4);
         chk("wrap_rbcrptrd", rbcrptrd, 4);
         chk("wrap_rd_valid_count", rdv_cnt, 20);
         crd_req = 1'b1;
         tick();
         crd_req = 1'b0;
         chk("wrap_empty_stall", stallcrd, 1);
         chk("wrap_empty_valid", crd_valid, 0);
      end

      // test_mode0 mid-burst clears state; later beats dropped.
      do_reset();
      grant_req(1'b0, "tm0_rq_c");
      beat(1'b0, 1'b1, 4'd0);
      beat(1'b0, 1'b1, 4'd1);
      beat(1'b0, 1'b1, 4'd2);
      test_mode0 = 1'b1;
      #2;
      chk("tm0_rq_valid_off", rb_if.rq_valid, 0);
      tick();
      test_mode0 = 1'b0;
      rb_if.beat_valid = 1'b1;
      rb_if.beat_sel = 1'b0;
      #2;
      chk("tm0_drop_we0", we0, 0);
      tick();
      rb_if.beat_valid = 1'b0;
      chk("tm0_stallcwd", stallcwd, 1);
      chk("tm0_rbcwptrd", rbcwptrd, 0);
      chk("tm0_rq_sel_color", rb_if.rq_sel, 0);
      chk("tm0_rq_valid_back", rb_if.rq_valid, 1);

      // test_mode1 kills strobes while pointers advance.
      do_reset();
      grant_req(1'b0, "tm1_rq_c");
      test_mode1 = 1'b1;
      rb_if.beat_valid = 1'b1;
      rb_if.beat_sel = 1'b0;
      #2;
      chk("tm1_we0_a", we0, 0);
      tick();
      #2;
      chk("tm1_we0_b", we0, 0);
      tick();
      rb_if.beat_valid = 1'b0;
      test_mode1 = 1'b0;
      tick();
      chk("tm1_rbcwptrd", rbcwptrd, 2);
      chk("tm1_stallcwd", stallcwd, 0);
      beat(1'b0, 1'b1, 4'd2);
      tick();

      chk("final_wq_c_drained", wq_c.size(), 0);
      chk("final_wq_z_drained", wq_z.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
